// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the default protection value
// used by initiators and responders on the peripheral interconnect.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage : axi4_lite_pkg

// File: rtl/axi4_lite.sv
// AXI4-Lite bus bundle shared by the initiator and the peripheral responders.
// The parent drives aclk/areset_n from the system clock and reset.
interface axi4_lite #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    aclk;
    logic                    areset_n;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [WIDTH-1:0]        wdata;
    logic [WIDTH/8-1:0]      wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [WIDTH-1:0]        rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        input  aclk, areset_n,
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  aclk, areset_n,
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface : axi4_lite

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator bridging a request/response port onto
// the bus; misaligned requests are answered locally with SLVERR.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter int         ADDR_WIDTH = 32,
    parameter logic [2:0] PROT       = AXI_PROT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    input  logic [WIDTH/8-1:0]    req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_err,
    axi4_lite.master              axi
);

    localparam int STRB_W = WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_BRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RSP   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  rsp_err_q, rsp_err_d;

    logic misaligned_s;
    logic aw_done_s;
    logic w_done_s;

    assign misaligned_s = (req_addr[OFF_W-1:0] != {OFF_W{1'b0}});
    // A channel counts as done once its valid is gone or it handshakes this cycle.
    assign aw_done_s    = !awvalid_q || axi.awready;
    assign w_done_s     = !wvalid_q || axi.wready;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= {ADDR_WIDTH{1'b0}};
            araddr_q    <= {ADDR_WIDTH{1'b0}};
            wdata_q     <= {WIDTH{1'b0}};
            wstrb_q     <= {STRB_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {WIDTH{1'b0}};
            rsp_resp_q  <= 2'b00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && misaligned_s) begin
                    state_d = ST_RSP;
                end else if (req_valid) begin
                    state_d = req_we ? ST_WRITE : ST_RADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = (aw_done_s && w_done_s) ? ST_BRESP : ST_WRITE;
            ST_BRESP: state_d = axi.bvalid ? ST_RSP : ST_BRESP;
            ST_RADDR: state_d = axi.arready ? ST_RDATA : ST_RADDR;
            ST_RDATA: state_d = axi.rvalid ? ST_RSP : ST_RDATA;
            ST_RSP:   state_d = rsp_ready ? ST_IDLE : ST_RSP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values for every registered output.
    always_comb begin
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && misaligned_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = {WIDTH{1'b0}};
                    rsp_resp_d  = SLVERR;
                    rsp_err_d   = 1'b1;
                end else if (req_valid && req_we) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                end else if (req_valid) begin
                    arvalid_d = 1'b1;
                    araddr_d  = req_addr;
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            ST_WRITE: begin
                awvalid_d = awvalid_q && !axi.awready;
                wvalid_d  = wvalid_q && !axi.wready;
                bready_d  = aw_done_s && w_done_s;
            end
            ST_BRESP: begin
                if (axi.bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = {WIDTH{1'b0}};
                    rsp_resp_d  = axi.bresp;
                    rsp_err_d   = (axi.bresp != OKAY);
                end else begin
                    bready_d = 1'b1;
                end
            end
            ST_RADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            ST_RDATA: begin
                // Read data is returned even with an error response.
                if (axi.rvalid) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = axi.rdata;
                    rsp_resp_d  = axi.rresp;
                    rsp_err_d   = (axi.rresp != OKAY);
                end else begin
                    rready_d = 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                arvalid_d   = 1'b0;
                bready_d    = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_err     = rsp_err_q;

    assign axi.awaddr  = awaddr_q;
    assign axi.awprot  = PROT;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = araddr_q;
    assign axi.arprot  = PROT;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

endmodule : axi4_lite_master

// File: tb/tb_axi4_lite_master.sv
// Randomized bench for axi4_lite_master: a wait-state-programmable memory slave
// on the bus and a transaction-level reference model of expected responses.
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    localparam int W  = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic [3:0]    req_wstrb;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_err;

    always #5 clk = ~clk;

    axi4_lite #(.WIDTH(W), .ADDR_WIDTH(AW)) axi ();
    assign axi.aclk     = clk;
    assign axi.areset_n = rst_n;

    axi4_lite_master #(.WIDTH(W), .ADDR_WIDTH(AW), .PROT(AXI_PROT_DEFAULT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .rsp_err   (rsp_err),
        .axi       (axi)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [31:0] slave_mem [1024];
    logic [31:0] ref_mem   [1024];
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic        ovr_en;
    logic [1:0]  ovr_resp;
    int          n_aw, n_w, n_ar, n_b, n_r, n_bph;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    // Responder policy: 0xE00 page answers SLVERR, 0xF00 page DECERR, else OKAY.
    function automatic logic [1:0] slave_policy(input logic [31:0] a);
        if (ovr_en)              return ovr_resp;
        else if (a[11:8] == 4'hE) return 2'b10;
        else if (a[11:8] == 4'hF) return 2'b11;
        else                      return 2'b00;
    endfunction

    // Memory slave: readies are one-cycle pulses raised only while valid is seen.
    initial begin
        int   aw_c, w_c, b_c, ar_c, r_c;
        logic got_aw, got_w, got_ar, aw_pp, w_pp, ar_pp, last_bready;
        logic [1:0] rs;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0;
        aw_pp = 1'b0; w_pp = 1'b0; ar_pp = 1'b0; last_bready = 1'b0;
        n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0; n_bph = 0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
                axi.arready = 1'b0; axi.rvalid = 1'b0;
                got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0;
                aw_pp = 1'b0; w_pp = 1'b0; ar_pp = 1'b0; last_bready = 1'b0;
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
            end else begin
                if (aw_pp) check_val("aw_hold", axi.awvalid, 1'b1);
                if (w_pp)  check_val("w_hold", axi.wvalid, 1'b1);
                if (ar_pp) check_val("ar_hold", axi.arvalid, 1'b1);
                if (axi.bready && !last_bready) n_bph++;
                last_bready = axi.bready;

                if (axi.awready) begin
                    axi.awready = 1'b0;
                    check_val("aw_drop", axi.awvalid, 1'b0);
                end else if (axi.awvalid && !got_aw) begin
                    if (aw_c >= aw_wait) begin
                        axi.awready = 1'b1; got_aw = 1'b1; cap_awaddr = axi.awaddr; n_aw++; aw_c = 0;
                    end else aw_c++;
                end

                if (axi.wready) begin
                    axi.wready = 1'b0;
                    check_val("w_drop", axi.wvalid, 1'b0);
                end else if (axi.wvalid && !got_w) begin
                    if (w_c >= w_wait) begin
                        axi.wready = 1'b1; got_w = 1'b1; cap_wdata = axi.wdata; cap_wstrb = axi.wstrb;
                        n_w++; w_c = 0;
                    end else w_c++;
                end

                if (axi.bvalid) begin
                    axi.bvalid = 1'b0;
                    check_val("b_drop", axi.bready, 1'b0);
                    got_aw = 1'b0; got_w = 1'b0;
                end else if (axi.bready && got_aw && got_w) begin
                    if (b_c >= b_wait) begin
                        rs = slave_policy(cap_awaddr);
                        axi.bresp = rs; axi.bvalid = 1'b1; n_b++; b_c = 0;
                        if (rs == 2'b00)
                            for (int i = 0; i < 4; i++)
                                if (cap_wstrb[i]) slave_mem[cap_awaddr[11:2]][8*i +: 8] = cap_wdata[8*i +: 8];
                    end else b_c++;
                end

                if (axi.arready) begin
                    axi.arready = 1'b0;
                    check_val("ar_drop", axi.arvalid, 1'b0);
                end else if (axi.arvalid && !got_ar) begin
                    if (ar_c >= ar_wait) begin
                        axi.arready = 1'b1; got_ar = 1'b1; cap_araddr = axi.araddr; n_ar++; ar_c = 0;
                    end else ar_c++;
                end

                if (axi.rvalid) begin
                    axi.rvalid = 1'b0;
                    check_val("r_drop", axi.rready, 1'b0);
                    got_ar = 1'b0;
                end else if (axi.rready && got_ar) begin
                    if (r_c >= r_wait) begin
                        axi.rdata = slave_mem[cap_araddr[11:2]];
                        axi.rresp = slave_policy(cap_araddr);
                        axi.rvalid = 1'b1; n_r++; r_c = 0;
                    end else r_c++;
                end

                aw_pp = axi.awvalid && !axi.awready;
                w_pp  = axi.wvalid && !axi.wready;
                ar_pp = axi.arvalid && !axi.arready;
            end
        end
    end

    // One full transaction, checked against the transaction-level model.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int hold);
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        int          e_lat, lat, aw0, w0, ar0, bph0;
        logic        misal, wr, rd;
        misal   = (addr[1:0] != 2'b00);
        wr      = we && !misal;
        rd      = !we && !misal;
        e_rdata = 32'h0;
        if (misal) begin
            e_resp = 2'b10;
            e_lat  = 1;
        end else if (we) begin
            e_resp = slave_policy(addr);
            e_lat  = 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait;
            if (e_resp == 2'b00)
                for (int i = 0; i < 4; i++)
                    if (wstrb[i]) ref_mem[addr[11:2]][8*i +: 8] = wdata[8*i +: 8];
        end else begin
            e_resp  = slave_policy(addr);
            e_rdata = ref_mem[addr[11:2]];
            e_lat   = 3 + ar_wait + r_wait;
        end
        aw0 = n_aw; w0 = n_w; ar0 = n_ar; bph0 = n_bph;

        @(negedge clk);
        check_val("req_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
        end while (!rsp_valid && lat < 100);
        check_val("latency", lat, e_lat);
        check_val("rsp_resp", rsp_resp, e_resp);
        check_val("rsp_rdata", rsp_rdata, e_rdata);
        check_val("rsp_err", rsp_err, (e_resp != 2'b00));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("rsp_stable", {rsp_valid, req_ready, rsp_resp, rsp_rdata},
                      {1'b1, 1'b0, e_resp, e_rdata});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("rsp_done", {rsp_valid, req_ready}, 2'b01);
        check_val("n_aw", n_aw - aw0, wr ? 1 : 0);
        check_val("n_w", n_w - w0, wr ? 1 : 0);
        check_val("n_bready", n_bph - bph0, wr ? 1 : 0);
        check_val("n_ar", n_ar - ar0, rd ? 1 : 0);
        if (wr) begin
            check_val("awaddr", cap_awaddr, addr);
            check_val("wdata", cap_wdata, wdata);
            check_val("wstrb", cap_wstrb, wstrb);
        end else if (rd) begin
            check_val("araddr", cap_araddr, addr);
        end
    endtask

    initial begin
        logic [31:0] v, a;
        int          cyc;
        logic        zw;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
        rsp_ready = 1'b0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        ovr_en = 1'b0; ovr_resp = 2'b00;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            slave_mem[i] = v;
            ref_mem[i]   = v;
        end

        repeat (3) @(negedge clk);
        check_val("rst_ctrl", {req_ready, rsp_valid, rsp_err, rsp_resp}, 5'b10000);
        check_val("rst_rdata", rsp_rdata, 32'h0);
        check_val("rst_axi_v", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b00000);
        check_val("rst_axi_d", {axi.awaddr, axi.araddr}, 64'h0);
        check_val("rst_axi_w", {axi.wdata, axi.wstrb}, 36'h0);
        check_val("prot", {axi.awprot, axi.arprot}, 6'b000000);
        #2 rst_n = 1'b1;

        do_req(1'b1, 32'h0, 32'h0000_00A5, 4'hF, 0);
        slave_mem[1] = 32'h0000_0028;
        ref_mem[1]   = 32'h0000_0028;
        do_req(1'b0, 32'h4, 32'h0, 4'h0, 0);

        aw_wait = 3; w_wait = 0;
        do_req(1'b1, 32'h10, 32'h1234_5678, 4'hF, 1);
        aw_wait = 0;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);

        do_req(1'b0, 32'h6, 32'h0, 4'h0, 0);

        slave_mem[15] = 32'hDEAD_BEEF;
        ref_mem[15]   = 32'hDEAD_BEEF;
        ovr_en = 1'b1; ovr_resp = 2'b11;
        do_req(1'b0, 32'h3C, 32'h0, 4'h0, 5);
        ovr_en = 1'b0;

        for (int t = 0; t < 60; t++) begin
            zw = ($urandom_range(0, 3) == 0);
            aw_wait = zw ? 0 : $urandom_range(0, 3);
            w_wait  = zw ? 0 : $urandom_range(0, 3);
            b_wait  = zw ? 0 : $urandom_range(0, 3);
            ar_wait = zw ? 0 : $urandom_range(0, 3);
            r_wait  = zw ? 0 : $urandom_range(0, 3);
            a = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 2));
        end

        aw_wait = 0; w_wait = 0; b_wait = 6; ar_wait = 0; r_wait = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!axi.bready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val("reach_bresp", axi.bready, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_val("rst_abort",
                     {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid, req_ready},
                     7'b0000001);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        b_wait = 0;
        do_req(1'b1, 32'h24, 32'h0BAD_CAFE, 4'hF, 0);
        do_req(1'b0, 32'h24, 32'h0, 4'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_axi4_lite_master
